// File: rtl/crc8_frame_appender.sv
// crc8_frame_appender: passes a byte stream through and appends a CRC-8 byte after each frame's last payload byte.
// Define CRC8_FRAME_COUNT_EN to add frame_count_o, a wrapping 16-bit count of emitted frames.
module crc8_frame_appender #(
    parameter logic [7:0] POLYNOMIAL = 8'h07,
    parameter logic [7:0] INIT       = 8'h00
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [7:0]  s_data_i,
    input  logic        s_valid_i,
    input  logic        s_last_i,
    output logic        s_ready_o,
    output logic [7:0]  m_data_o,
    output logic        m_valid_o,
    output logic        m_last_o,
`ifdef CRC8_FRAME_COUNT_EN
    output logic [15:0] frame_count_o,
`endif
    input  logic        m_ready_i
);
    typedef enum logic {PAYLOAD, APPEND} state_t;
    state_t     state_q, state_d;
    logic [7:0] crc_q, crc_d, data_q, data_d;
    logic       valid_q, valid_d, last_q, last_d, slot_free, s_fire;

    function automatic logic [7:0] crc_next(input logic [7:0] crc, input logic [7:0] data);
        logic [7:0] c;
        c = crc ^ data;
        for (int i = 0; i < 8; i++) c = c[7] ? ((c << 1) ^ POLYNOMIAL) : (c << 1);
        return c;
    endfunction

    assign slot_free = !valid_q | m_ready_i;
    // Gated by rst_i so nothing is accepted while reset is held.
    assign s_ready_o = !rst_i && state_q == PAYLOAD && slot_free;
    assign s_fire    = s_valid_i & s_ready_o;
    assign m_data_o  = data_q;
    assign m_valid_o = valid_q;
    assign m_last_o  = last_q;

    always_comb begin
        state_d = state_q;
        crc_d   = crc_q;
        data_d  = data_q;
        last_d  = last_q;
        valid_d = slot_free ? 1'b0 : valid_q;
        if (state_q == PAYLOAD && s_fire) begin
            data_d  = s_data_i;
            last_d  = 1'b0;
            valid_d = 1'b1;
            crc_d   = crc_next(crc_q, s_data_i);
            state_d = s_last_i ? APPEND : PAYLOAD;
        end else if (state_q == APPEND && slot_free) begin
            data_d  = crc_q;
            last_d  = 1'b1;
            valid_d = 1'b1;
            crc_d   = INIT;
            state_d = PAYLOAD;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= PAYLOAD;
            crc_q   <= INIT;
            data_q  <= 8'h00;
            valid_q <= 1'b0;
            last_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            crc_q   <= crc_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            last_q  <= last_d;
        end
    end

`ifdef CRC8_FRAME_COUNT_EN
    logic [15:0] frame_count_q;
    assign frame_count_o = frame_count_q;
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) frame_count_q <= 16'h0000;
        else if (valid_q & m_ready_i & last_q) frame_count_q <= frame_count_q + 16'h0001;
    end
`endif
endmodule

// File: tb/tb_crc8_frame_appender.sv
// tb_crc8_frame_appender: random and directed frames checked against a bit-serial CRC-8 scoreboard.
module tb_crc8_frame_appender;
    typedef logic [7:0] bq_t[$];
    localparam logic [7:0] POLY = 8'h07;
    localparam logic [7:0] INIT = 8'h00;

    logic       clk = 0, rst_i = 1;
    logic [7:0] s_data = 0, m_data;
    logic       s_valid = 0, s_last = 0, s_ready, m_valid, m_last, m_ready = 1;
`ifdef CRC8_FRAME_COUNT_EN
    logic [15:0] frame_count;
`endif

    int n_chk = 0, n_pass = 0, mode = 0, beats = 0, lowcnt = 0;
    logic [8:0] exp_q[$];
    logic [7:0] last_crc = 0;
    logic       stall = 0;
    logic [9:0] snap = 0;

    crc8_frame_appender dut (
`ifdef CRC8_FRAME_COUNT_EN
        .frame_count_o(frame_count),
`endif
        .clk_i(clk), .rst_i(rst_i), .s_data_i(s_data), .s_valid_i(s_valid), .s_last_i(s_last),
        .s_ready_o(s_ready), .m_data_o(m_data), .m_valid_o(m_valid), .m_last_o(m_last),
        .m_ready_i(m_ready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    // Polynomial long division one message bit at a time, MSB first.
    function automatic logic [7:0] ref_crc(input bq_t b);
        logic [7:0] c = INIT;
        logic       fb;
        foreach (b[k])
            for (int i = 7; i >= 0; i--) begin
                fb = c[7] ^ b[k][i];
                c  = {c[6:0], 1'b0} ^ (fb ? POLY : 8'h00);
            end
        return c;
    endfunction

    task automatic send(input bq_t b, input bit last, input int gap_max);
        int n;
        foreach (b[i]) exp_q.push_back({1'b0, b[i]});
        if (last) exp_q.push_back({1'b1, ref_crc(b)});
        foreach (b[i]) begin
            if (gap_max > 0) begin
                s_valid = 0;
                repeat ($urandom_range(0, gap_max)) begin @(posedge clk); #1; end
            end
            s_valid = 1;
            s_data  = b[i];
            s_last  = last && i == b.size() - 1;
            n = 0;
            @(negedge clk);
            while (!s_ready && n < 200) begin @(negedge clk); n++; end
            if (n >= 200) check("ready_timeout", 32'(s_ready), 1);
            @(posedge clk); #1;
        end
        s_valid = 0;
        s_last  = 0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 500) begin @(negedge clk); n++; end
        if (n >= 500) check("drain_timeout", exp_q.size(), 0);
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
    endtask

    always begin
        @(posedge clk); #1;
        m_ready = mode == 0 ? 1'b1 : mode == 1 ? (beats >= 0 && ($time / 10) % 4 inside {0, 3}) : 1'($urandom_range(0, 1));
    end

    always @(negedge clk) begin
        if (!rst_i) begin
            if (stall) check("stall_stable", {m_valid, m_last, m_data}, snap);
            if (m_valid && m_ready) begin
                beats++;
                if (exp_q.size() == 0) check("extra_beat", 32'(m_valid), 0);
                else begin
                    logic [8:0] e;
                    e = exp_q.pop_front();
                    check("data", m_data, e[7:0]);
                    check("last", m_last, e[8]);
                end
                if (m_last) last_crc = m_data;
            end
            if (!s_ready) lowcnt++;
            stall = m_valid & !m_ready;
            snap  = {m_valid, m_last, m_data};
        end else stall = 0;
    end

    initial begin
        bq_t s9, b;
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        bq_t s9, b;
        s9 = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
        @(negedge clk);
        check("rst_s_ready", 32'(s_ready), 0);
        check("rst_m_valid", 32'(m_valid), 0);
        check("rst_m_data", m_data, 0);
        @(posedge clk); #1;
        rst_i = 0;

        beats = 0; lowcnt = 0;
        send(s9, 1, 0);
        drain();
        check("check_crc", last_crc, 8'hF4);
        check("check_beats", beats, 10);
        check("check_bubble", lowcnt, 1);

        send('{8'h01}, 1, 0);
        drain();
        check("single01_crc", last_crc, 8'h07);
        send('{8'h00}, 1, 0);
        drain();
        check("single00_crc", last_crc, 8'h00);

        mode = 1; beats = 0;
        send(s9, 1, 0);
        drain();
        check("bp_crc", last_crc, 8'hF4);
        check("bp_beats", beats, 10);
        mode = 0;

        send('{8'h31, 8'h32}, 0, 0);
        drain();
        rst_i = 1;
        @(negedge clk);
        check("midrst_m_valid", 32'(m_valid), 0);
        check("midrst_s_ready", 32'(s_ready), 0);
        @(posedge clk); #1;
        rst_i = 0;
        send(s9, 1, 0);
        drain();
        check("midrst_crc", last_crc, 8'hF4);

        mode = 2;
        for (int f = 0; f < 25; f++) begin
            b = {};
            for (int k = 0; k < int'($urandom_range(1, 8)); k++) b.push_back(8'($urandom));
            send(b, 1, 2);
        end
        drain();
        mode = 0;

`ifdef CRC8_FRAME_COUNT_EN
        rst_i = 1;
        @(posedge clk); #1;
        rst_i = 0;
        for (int f = 0; f < 3; f++) send('{8'($urandom), 8'($urandom)}, 1, 0);
        drain();
        check("frame_count3", frame_count, 3);
        force dut.frame_count_q = 16'hFFFF;
        @(posedge clk); #1;
        release dut.frame_count_q;
        send('{8'h5A}, 1, 0);
        drain();
        check("frame_count_wrap", frame_count, 0);
`endif
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
